dram_responder: RTL and testbench

Data-RAM responder for the core's load/store port. It accepts one request at a time from the EX-side request channel and commits writes on acceptance. For reads, it returns word data to the MEM stage after a programmable number of wait states, then holds that response until MEM consumes it or the pipeline flushes it. It serves as the single-cycle-or-slower data memory model and wait-state generator that exercises MEM stalls.

---
 rtl/dram_responder.sv | 122 ++++++++++++
 tb/tb_dram_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: data-RAM model and wait-state generator for the load/store port.
// It accepts one request at a time. Stores commit on the accepting edge.
// A load returns its word after LATENCY cycles and holds it until MEM consumes it or a flush drops it.
`ifndef XLEN
`define XLEN 32
`endif

module dram_responder #(
   parameter int DEPTH   = 4096,  // words; power of two, >= 2
   parameter int LATENCY = 1      // acceptance-to-data_ok cycles, 1..8
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              dram_req,
   input  logic              dram_write,
   input  logic [`XLEN-1:0]  dram_addr,
   input  logic [3:0]        dram_wstrb,
   input  logic [`XLEN-1:0]  dram_wdata,
   output logic              dram_addr_ok,
   input  logic              dram_flush,
   input  logic              dram_resp_ready,
   output logic              dram_data_ok,
   output logic [`XLEN-1:0]  dram_rdata
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   // LATENCY=1 goes straight to RESP. Longer latencies count down in WAIT.
   localparam state_t     LOAD_NEXT = (LATENCY == 1) ? ST_RESP : ST_WAIT;
   localparam logic [2:0] CNT_INIT  = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

   // Byte-lane merge of store data into an existing word
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++)
         if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
      return res;
   endfunction

   logic [31:0]   mem [DEPTH];
   state_t        state_q, state_nxt;
   logic [2:0]    cnt_q;
   logic [31:0]   rdata_p1;
   logic [AW-1:0] idx;
   logic          accept, store_acc, load_acc;
   logic          unused_addr_bits;

   // Address bits outside the word index do not affect the access, so addresses wrap modulo DEPTH words
   assign idx              = dram_addr[AW+1:2];
   assign unused_addr_bits = ^{dram_addr[`XLEN-1:AW+2], dram_addr[1:0]};

   assign accept    = dram_req && dram_addr_ok;
   assign store_acc = accept && dram_write;
   assign load_acc  = accept && !dram_write;

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state logic. A flush outranks resp_ready and any new request
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_acc) state_nxt = LOAD_NEXT;
         end
         ST_WAIT: begin
            if (dram_flush)       state_nxt = ST_IDLE;
            else if (cnt_q == '0) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (dram_flush)           state_nxt = ST_IDLE;
            else if (dram_resp_ready) state_nxt = load_acc ? LOAD_NEXT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: acceptance handshake and response valid
   always_comb begin
      dram_addr_ok = 1'b0;
      dram_data_ok = 1'b0;
      case (state_q)
         ST_IDLE: dram_addr_ok = !dram_flush;
         ST_RESP: begin
            dram_addr_ok = dram_resp_ready && !dram_flush;
            dram_data_ok = 1'b1;
         end
         default: ;
      endcase
   end

   assign dram_rdata = rdata_p1;

   // Read sample and wait-state counter. The sample is taken only on load acceptance, so it holds through RESP
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q    <= '0;
         rdata_p1 <= '0;
      end else begin
         if (load_acc) begin
            rdata_p1 <= mem[idx];
            cnt_q    <= CNT_INIT;
         end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 3'd1;
         end
      end
   end

   // Store commit. The memory array has no reset, and a reset does not disturb it
   always_ff @(posedge clk) begin
      if (store_acc) mem[idx] <= merge_bytes(mem[idx], dram_wdata, dram_wstrb);
   end

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder. Instance A uses LATENCY=1 and instance B uses LATENCY=4.
// Both share every input except dram_req. Each instance stays idle while the other one is exercised.
module tb_dram_responder;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req_a, req_b, wr, flush, ready;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
   logic [31:0] rdata_a, rdata_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dram_responder #(.DEPTH(4096), .LATENCY(1)) u_a (
      .clk(clk), .rst_b(rst_b), .dram_req(req_a), .dram_write(wr), .dram_addr(addr),
      .dram_wstrb(wstrb), .dram_wdata(wdata), .dram_addr_ok(addr_ok_a), .dram_flush(flush),
      .dram_resp_ready(ready), .dram_data_ok(data_ok_a), .dram_rdata(rdata_a));

   dram_responder #(.DEPTH(4096), .LATENCY(4)) u_b (
      .clk(clk), .rst_b(rst_b), .dram_req(req_b), .dram_write(wr), .dram_addr(addr),
      .dram_wstrb(wstrb), .dram_wdata(wdata), .dram_addr_ok(addr_ok_b), .dram_flush(flush),
      .dram_resp_ready(ready), .dram_data_ok(data_ok_b), .dram_rdata(rdata_b));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ra, input logic rb, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      req_a = ra; req_b = rb; wr = w; addr = a; wstrb = s; wdata = d;
      #1;
   endtask

   initial begin
      rst_b = 1'b0; flush = 1'b0; ready = 1'b0;
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      tick(); tick();
      chk1 ("rst_data_ok_a", data_ok_a, 1'b0);
      chk32("rst_rdata_a",   rdata_a,   32'h0);
      chk1 ("rst_data_ok_b", data_ok_b, 1'b0);
      chk32("rst_rdata_b",   rdata_b,   32'h0);
      #3 rst_b = 1'b1;
      tick();
      chk1 ("rst_rel_addr_ok_a", addr_ok_a, 1'b1);

      // ---- A: full store then load, LATENCY=1
      drive(1, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF);
      chk1 ("st_addr_ok", addr_ok_a, 1'b1);
      tick();
      drive(1, 0, 0, 32'h100, 4'h0, 32'h0);
      chk1 ("ld_addr_ok", addr_ok_a, 1'b1);
      chk1 ("ld_no_resp_yet", data_ok_a, 1'b0);
      tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk1 ("ld_data_ok", data_ok_a, 1'b1);
      chk32("ld_rdata", rdata_a, 32'hDEADBEEF);
      ready = 1'b1; tick(); ready = 1'b0; #1;
      chk1 ("consumed_idle", data_ok_a, 1'b0);

      // ---- A: partial store, then back-to-back load
      drive(1, 0, 1, 32'h300, 4'hF, 32'hCAFEF00D); tick();
      drive(1, 0, 1, 32'h204, 4'hF, 32'h11223344); tick();
      drive(1, 0, 1, 32'h204, 4'b0100, 32'h00AA0000);
      chk1 ("st_per_cycle", addr_ok_a, 1'b1);
      tick();
      drive(1, 0, 0, 32'h204, 4'h0, 32'h0); tick();
      ready = 1'b1;
      drive(1, 0, 0, 32'h300, 4'h0, 32'h0);
      chk1 ("partial_data_ok", data_ok_a, 1'b1);
      chk32("partial_rdata", rdata_a, 32'h11AA3344);
      chk1 ("b2b_addr_ok", addr_ok_a, 1'b1);
      tick();
      ready = 1'b0;
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk1 ("b2b_data_ok", data_ok_a, 1'b1);
      chk32("b2b_rdata", rdata_a, 32'hCAFEF00D);

      // ---- A: flush in RESP with ready and a new request
      flush = 1'b1; ready = 1'b1;
      drive(1, 0, 0, 32'h100, 4'h0, 32'h0);
      chk1 ("flush_resp_addr_ok", addr_ok_a, 1'b0);
      tick();
      flush = 1'b0; ready = 1'b0;
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk1 ("flush_resp_data_ok", data_ok_a, 1'b0);
      chk1 ("flush_resp_idle", addr_ok_a, 1'b1);
      tick();
      chk1 ("flush_resp_no_stale", data_ok_a, 1'b0);

      // ---- A: address wrap, store 0x4000 then load 0x0
      drive(1, 0, 1, 32'h4000, 4'hF, 32'h12345678); tick();
      drive(1, 0, 0, 32'h0, 4'h0, 32'h0); tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk32("wrap_rdata", rdata_a, 32'h12345678);
      ready = 1'b1; tick(); ready = 1'b0; #1;

      // ---- B: LATENCY=4 timing and hold
      drive(0, 1, 1, 32'h100, 4'hF, 32'hA5A55A5A); tick();
      drive(0, 1, 0, 32'h100, 4'h0, 32'h0); tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk1 ("l4_wait_addr_ok", addr_ok_b, 1'b0);
      chk1 ("l4_c1", data_ok_b, 1'b0);
      tick(); chk1("l4_c2", data_ok_b, 1'b0);
      tick(); chk1("l4_c3", data_ok_b, 1'b0);
      tick(); chk1("l4_c4", data_ok_b, 1'b1);
      drive(0, 1, 0, 32'h204, 4'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk1 ("hold_data_ok", data_ok_b, 1'b1);
         chk32("hold_rdata", rdata_b, 32'hA5A55A5A);
         chk1 ("hold_addr_ok", addr_ok_b, 1'b0);
         tick();
      end
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      ready = 1'b1; #1;
      chk1 ("release_addr_ok", addr_ok_b, 1'b1);
      tick(); ready = 1'b0; #1;
      chk1 ("release_idle", data_ok_b, 1'b0);

      // ---- B: flush in WAIT
      drive(0, 1, 0, 32'h100, 4'h0, 32'h0); tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0); tick();
      flush = 1'b1; #1;
      chk1 ("flush_wait_addr_ok", addr_ok_b, 1'b0);
      tick(); flush = 1'b0; #1;
      chk1 ("flush_wait_idle", addr_ok_b, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk1 ("flush_wait_no_resp", data_ok_b, 1'b0);
         tick();
      end

      // ---- B: reset mid-WAIT, then reset in RESP, memory retained
      drive(0, 1, 0, 32'h100, 4'h0, 32'h0); tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      rst_b = 1'b0; #1;
      chk1 ("rst_wait_data_ok", data_ok_b, 1'b0);
      rst_b = 1'b1; #1;
      chk1 ("rst_wait_addr_ok", addr_ok_b, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      chk1 ("rst_wait_no_resp", data_ok_b, 1'b0);
      drive(0, 1, 0, 32'h100, 4'h0, 32'h0); tick();
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      tick(); tick(); tick();
      chk1 ("pre_rst_resp", data_ok_b, 1'b1);
      chk32("mem_kept", rdata_b, 32'hA5A55A5A);
      rst_b = 1'b0; #1;
      chk1 ("rst_resp_data_ok", data_ok_b, 1'b0);
      chk32("rst_resp_rdata", rdata_b, 32'h0);
      rst_b = 1'b1;
      tick();
      chk1 ("rst_resp_addr_ok", addr_ok_b, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
